// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// PIPE_HAZARD_PERF_EN (see pipe_hazard_ctrl) does not affect this package.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam logic [4:0] NOP_REG = 5'd0;

  // A load writing r0 never creates a dependency.
  function automatic logic load_use(input logic       ld,
                                    input logic [4:0] wr,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt);
    return ld && (wr != NOP_REG) && ((wr == rs) || (wr == rt));
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Req/ack sequencer for the multi-cycle data memory; stalls the pipe while the MEM op is outstanding.
//   state | meaning
//   IDLE  | no access in flight; a MEM op launches a request (stall this cycle)
//   REQ   | dmem_req high, waiting for ack or timeout (stall)
//   DONE  | access finished, pipeline advances one edge
module mem_access_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_op,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic [31:0] rdata_q,
  output logic        mem_err,
  output logic        mem_stall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign dmem_req    = (state == REQ);

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          state_nxt = REQ;
          mem_stall = 1'b1;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dmem_ack || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_err <= 1'b0;
      case (state)
        REQ: begin
          cnt <= cnt + 1'b1;
          // ack takes priority over a coincident timeout
          if (dmem_ack) begin
            rdata_q <= dmem_rdata;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            mem_err <= 1'b1;
          end
        end
        DONE:    cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage enables, flushes and bubbles for the 5-stage core: memory stall, branch flush, load-use.
// Define PIPE_HAZARD_PERF_EN to add saturating stall / load-use performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_WriteReg,
  input  logic        ex_branch_taken,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  output logic        dmem_req,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] rdata_q,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_bubble,
  output logic        mem_err
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_lu_cnt
`endif
);

  logic mem_stall;
  logic lu_hazard;

  mem_access_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_mem_access (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_op    (mem_MemRead | mem_MemWrite),
    .dmem_ack  (dmem_ack),
    .dmem_rdata(dmem_rdata),
    .dmem_req  (dmem_req),
    .rdata_q   (rdata_q),
    .mem_err   (mem_err),
    .mem_stall (mem_stall)
  );

  assign lu_hazard = load_use(ex_MemRead, ex_WriteReg, id_rs, id_rt);

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (mem_stall) begin
      // flushes wait until the freeze lifts so a branch is not lost
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic lu_stall;
  assign lu_stall = !mem_stall && !ex_branch_taken && lu_hazard;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_lu_cnt    <= '0;
    end else begin
      if (mem_stall && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (lu_stall && (perf_lu_cnt != 32'hFFFF_FFFF))
        perf_lu_cnt <= perf_lu_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (TIMEOUT_CYCLES=4); perf checks when PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs, id_rt, ex_WriteReg;
  logic        ex_MemRead, ex_branch_taken, mem_MemRead, mem_MemWrite;
  logic        dmem_req, dmem_ack;
  logic [31:0] dmem_rdata, rdata_q;
  logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, mem_err;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_lu_cnt;
`endif

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .ex_MemRead     (ex_MemRead),
    .ex_WriteReg    (ex_WriteReg),
    .ex_branch_taken(ex_branch_taken),
    .mem_MemRead    (mem_MemRead),
    .mem_MemWrite   (mem_MemWrite),
    .dmem_req       (dmem_req),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .rdata_q        (rdata_q),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exmem_en       (exmem_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .memwb_bubble   (memwb_bubble),
    .mem_err        (mem_err)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_lu_cnt    (perf_lu_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
  localparam logic [6:0] CTL_RUN    = 7'b1111000;
  localparam logic [6:0] CTL_STALL  = 7'b0000001;
  localparam logic [6:0] CTL_BRANCH = 7'b1111110;
  localparam logic [6:0] CTL_LU     = 7'b0011010;

  logic [6:0] ctl_act;
  assign ctl_act = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] rs, rt, wr;
    logic       mr, br;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[8];

  // reference model state for the random phase
  int          busy;      // 0: no access, 1: waiting for memory, 2: finishing
  int          waited;
  logic [31:0] m_rdata;
  logic        m_err;
  int          m_stall_cnt, m_lu_cnt;

  initial begin
    logic       st, lu;
    logic [6:0] e;

    reset_n = 1'b0;
    id_rs = '0; id_rt = '0; ex_WriteReg = '0;
    ex_MemRead = 1'b0; ex_branch_taken = 1'b0;
    mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;

    tbl[0] = '{rs:5'd1, rt:5'd2, wr:5'd8, mr:1'b0, br:1'b0, exp:CTL_RUN};
    tbl[1] = '{rs:5'd1, rt:5'd8, wr:5'd8, mr:1'b1, br:1'b0, exp:CTL_LU};
    tbl[2] = '{rs:5'd9, rt:5'd3, wr:5'd9, mr:1'b1, br:1'b0, exp:CTL_LU};
    tbl[3] = '{rs:5'd0, rt:5'd0, wr:5'd0, mr:1'b1, br:1'b0, exp:CTL_RUN};
    tbl[4] = '{rs:5'd8, rt:5'd8, wr:5'd8, mr:1'b0, br:1'b0, exp:CTL_RUN};
    tbl[5] = '{rs:5'd9, rt:5'd1, wr:5'd9, mr:1'b1, br:1'b1, exp:CTL_BRANCH};
    tbl[6] = '{rs:5'd1, rt:5'd2, wr:5'd3, mr:1'b0, br:1'b1, exp:CTL_BRANCH};
    tbl[7] = '{rs:5'd4, rt:5'd5, wr:5'd6, mr:1'b1, br:1'b0, exp:CTL_RUN};

    #3;
    chk("reset_dmem_req", dmem_req, 1'b0);
    chk("reset_rdata_q", rdata_q, 32'h0);
    chk("reset_mem_err", mem_err, 1'b0);
    chk("reset_ctl", ctl_act, CTL_RUN);
    #9 reset_n = 1'b1;
    @(posedge clk); #1;

    // hazard priority table, FSM idle throughout
    for (int i = 0; i < 8; i++) begin
      id_rs = tbl[i].rs; id_rt = tbl[i].rt; ex_WriteReg = tbl[i].wr;
      ex_MemRead = tbl[i].mr; ex_branch_taken = tbl[i].br;
      @(negedge clk);
      chk($sformatf("table_ctl_%0d", i), ctl_act, tbl[i].exp);
      @(posedge clk); #1;
    end
    id_rs = '0; id_rt = '0; ex_WriteReg = '0; ex_MemRead = 1'b0; ex_branch_taken = 1'b0;

    // load with ack in the third request cycle: 4 frozen cycles, then advance
    for (int c = 0; c < 6; c++) begin
      mem_MemRead = (c < 4);
      dmem_ack    = (c == 3);
      dmem_rdata  = (c == 3) ? 32'h1234_5678 : 32'h0;
      @(negedge clk);
      chk($sformatf("load_exmem_en_c%0d", c), exmem_en, (c < 4) ? 1'b0 : 1'b1);
      chk($sformatf("load_dmem_req_c%0d", c), dmem_req, (c >= 1 && c <= 3) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end
    chk("load_rdata_q", rdata_q, 32'h1234_5678);

    // timeout: no ack, request held TO cycles, error pulse in DONE, data cleared
    for (int c = 0; c < 7; c++) begin
      mem_MemWrite = (c <= 4);
      dmem_ack     = 1'b0;
      @(negedge clk);
      chk($sformatf("to_dmem_req_c%0d", c), dmem_req, (c >= 1 && c <= TO) ? 1'b1 : 1'b0);
      chk($sformatf("to_mem_err_c%0d", c), mem_err, (c == TO + 1) ? 1'b1 : 1'b0);
      if (c == TO + 1) chk("to_rdata_q", rdata_q, 32'h0);
      @(posedge clk); #1;
    end

    // back-to-back sw then lw; acks outside REQ must be ignored
    for (int c = 0; c < 7; c++) begin
      mem_MemWrite = (c <= 1);
      mem_MemRead  = (c >= 2 && c <= 4);
      dmem_ack     = (c >= 1 && c <= 4) || (c == 6);
      dmem_rdata   = (c == 4) ? 32'hCAFE_BABE : (32'h0BAD_0000 + 32'(c));
      @(negedge clk);
      chk($sformatf("b2b_exmem_en_c%0d", c), exmem_en, (c == 0 || c == 1 || c == 3 || c == 4) ? 1'b0 : 1'b1);
      chk($sformatf("b2b_dmem_req_c%0d", c), dmem_req, (c == 1 || c == 4) ? 1'b1 : 1'b0);
      if (c == 5) chk("b2b_rdata_done", rdata_q, 32'hCAFE_BABE);
      @(posedge clk); #1;
    end
    mem_MemRead = 1'b0; mem_MemWrite = 1'b0; dmem_ack = 1'b0;
    chk("b2b_rdata_after_idle_ack", rdata_q, 32'hCAFE_BABE);
`ifdef PIPE_HAZARD_PERF_EN
    // 4 (load) + 5 (timeout) + 4 (back-to-back) stall cycles; 2 load-use table rows
    chk("perf_stall_cnt", perf_stall_cnt, 32'd13);
    chk("perf_lu_cnt", perf_lu_cnt, 32'd2);
`endif

    // reset asserted while requesting drops dmem_req without waiting for an edge
    mem_MemRead = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_before", dmem_req, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_req_drop", dmem_req, 1'b0);
    chk("rst_rdata_clear", rdata_q, 32'h0);
    mem_MemRead = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_idle_ctl", ctl_act, CTL_RUN);
    chk("rst_idle_req", dmem_req, 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif

    // randomized traffic against the behavioural model
    busy = 0; waited = 0; m_rdata = 32'h0; m_err = 1'b0;
    m_stall_cnt = 0; m_lu_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_WriteReg     = 5'($urandom_range(0, 3));
      ex_MemRead      = ($urandom_range(0, 1) == 1);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_MemRead     = ($urandom_range(0, 3) == 0);
      mem_MemWrite    = ($urandom_range(0, 5) == 0);
      dmem_ack        = ($urandom_range(0, 2) == 0);
      dmem_rdata      = $urandom;

      st = (busy == 1) || (busy == 0 && (mem_MemRead || mem_MemWrite));
      lu = ex_MemRead && (ex_WriteReg != 5'd0) && (ex_WriteReg == id_rs || ex_WriteReg == id_rt);
      if (st)                   e = CTL_STALL;
      else if (ex_branch_taken) e = CTL_BRANCH;
      else if (lu)              e = CTL_LU;
      else                      e = CTL_RUN;

      @(negedge clk);
      chk("rand_ctl", ctl_act, e);
      chk("rand_dmem_req", dmem_req, (busy == 1));
      chk("rand_rdata_q", rdata_q, m_rdata);
      chk("rand_mem_err", mem_err, m_err);
`ifdef PIPE_HAZARD_PERF_EN
      chk("rand_perf_stall", perf_stall_cnt, 32'(m_stall_cnt));
      chk("rand_perf_lu", perf_lu_cnt, 32'(m_lu_cnt));
`endif
      if (st) m_stall_cnt++;
      else if (!ex_branch_taken && lu) m_lu_cnt++;

      m_err = 1'b0;
      if (busy == 0) begin
        if (mem_MemRead || mem_MemWrite) begin
          busy = 1; waited = 0;
        end
      end else if (busy == 1) begin
        waited++;
        if (dmem_ack) begin
          m_rdata = dmem_rdata; busy = 2;
        end else if (waited == TO) begin
          m_rdata = 32'h0; m_err = 1'b1; busy = 2;
        end
      end else begin
        busy = 0;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
